// File: rtl/eth_axis_rx_core_if.sv
// Purpose : byte-stream and Ethernet-header channel bundles used by eth_axis_rx_core.
// Latency : none (wires only).
// Backpressure: tready / ready driven by the consumer side of each modport.
// Ports   : eth_axis_rx_core_if = AXI-Stream beat (tdata/tkeep/tvalid/tready/tlast/tuser);
//           eth_hdr_if = parsed header (valid/ready, dest_mac, src_mac, eth_type).

interface eth_axis_rx_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

interface eth_hdr_if;
  logic        valid;
  logic        ready;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;

  modport master (output valid, dest_mac, src_mac, eth_type, input ready);
  modport slave  (input valid, dest_mac, src_mac, eth_type, output ready);
endinterface

// File: rtl/eth_axis_rx_core.sv
// Purpose : strips the 14-byte Ethernet header off a byte stream into a header channel, forwards the payload.
// Latency : header valid 1 cycle after byte 13; each payload byte appears 1 cycle after acceptance.
// Backpressure: header stage stalls while a header is unaccepted; payload uses a 2-entry skid buffer.
// Ports   : clk, reset (sync, active-low); s_axis (slave stream in); m_eth_hdr (header out);
//           m_eth_payload_axis (master stream out); busy; error_header_early_termination (1-cycle pulse).

module eth_axis_rx_core #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  eth_axis_rx_core_if.slave         s_axis,
  eth_hdr_if.master                 m_eth_hdr,
  eth_axis_rx_core_if.master        m_eth_payload_axis,
  output logic                      busy,
  output logic                      error_header_early_termination
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("eth_axis_rx_core supports DATA_WIDTH = 8 only");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_DROP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  user;
  } beat_t;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [47:0] dest_q, dest_d, src_q, src_d;
  logic [15:0] type_q, type_d;
  logic        hdr_vld_q, hdr_vld_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        run_q;               // low during reset, holds s_axis_tready off
  beat_t       out_q, out_d, tmp_q, tmp_d, in_beat;
  logic        out_vld_q, out_vld_d, tmp_vld_q, tmp_vld_d;
  logic        s_rdy, in_fire, pay_fire;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dest_d    = dest_q;
    src_d     = src_q;
    type_d    = type_q;
    hdr_vld_d = hdr_vld_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    tmp_d     = tmp_q;
    tmp_vld_d = tmp_vld_q;
    s_rdy     = 1'b0;
    pay_fire  = 1'b0;

    in_beat.dat  = s_axis.tdata;
    in_beat.keep = s_axis.tkeep;
    in_beat.last = s_axis.tlast;
    in_beat.user = s_axis.tuser;

    if (hdr_vld_q && m_eth_hdr.ready) hdr_vld_d = 1'b0;

    // Header bytes wait for the previous header to drain; payload bytes only for skid space.
    case (state_q)
      ST_IDLE, ST_HEADER: s_rdy = run_q && !hdr_vld_q;
      ST_PAYLOAD:         s_rdy = run_q && !tmp_vld_q;
      default:            s_rdy = 1'b0;
    endcase
    in_fire = s_axis.tvalid && s_rdy;

    case (state_q)
      ST_IDLE, ST_HEADER: begin
        if (in_fire) begin
          busy_d = 1'b1;
          if (ptr_q < 4'd6)       dest_d = {dest_q[39:0], s_axis.tdata[7:0]};
          else if (ptr_q < 4'd12) src_d  = {src_q[39:0], s_axis.tdata[7:0]};
          else                    type_d = {type_q[7:0], s_axis.tdata[7:0]};
          if (s_axis.tlast) begin
            // Frame ended inside the header: flag it and drop the frame silently.
            err_d   = 1'b1;
            busy_d  = 1'b0;
            ptr_d   = 4'd0;
            state_d = ST_IDLE;
          end else if (ptr_q == 4'd13) begin
            hdr_vld_d = 1'b1;
            ptr_d     = 4'd0;
            state_d   = ST_PAYLOAD;
          end else begin
            ptr_d   = ptr_q + 4'd1;
            state_d = ST_HEADER;
          end
        end
      end
      ST_PAYLOAD: begin
        pay_fire = in_fire;
        if (in_fire && s_axis.tlast) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Skid buffer: output register refills from temp first so byte order is kept.
    if (!out_vld_q || m_eth_payload_axis.tready) begin
      if (tmp_vld_q) begin
        out_d     = tmp_q;
        out_vld_d = 1'b1;
        tmp_vld_d = pay_fire;
        if (pay_fire) tmp_d = in_beat;
      end else begin
        out_vld_d = pay_fire;
        if (pay_fire) out_d = in_beat;
      end
    end else if (pay_fire) begin
      tmp_d     = in_beat;
      tmp_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 4'd0;
      dest_q    <= '0;
      src_q     <= '0;
      type_q    <= '0;
      hdr_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      tmp_q     <= '0;
      tmp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      type_q    <= type_d;
      hdr_vld_q <= hdr_vld_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      run_q     <= 1'b1;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      tmp_q     <= tmp_d;
      tmp_vld_q <= tmp_vld_d;
    end
  end

  assign s_axis.tready                  = s_rdy;
  assign m_eth_hdr.valid                = hdr_vld_q;
  assign m_eth_hdr.dest_mac             = dest_q;
  assign m_eth_hdr.src_mac              = src_q;
  assign m_eth_hdr.eth_type             = type_q;
  assign m_eth_payload_axis.tdata       = out_q.dat;
  assign m_eth_payload_axis.tkeep       = KEEP_ENABLE ? out_q.keep : {KEEP_WIDTH{1'b1}};
  assign m_eth_payload_axis.tvalid      = out_vld_q;
  assign m_eth_payload_axis.tlast       = out_q.last;
  assign m_eth_payload_axis.tuser       = out_q.user;
  assign busy                           = busy_q;
  assign error_header_early_termination = err_q;

endmodule

// File: tb/tb_eth_axis_rx_core.sv
// Purpose : directed self-checking bench for eth_axis_rx_core.
// Latency : n/a.
// Backpressure: bench drives both sink readies (header and payload).

module tb_eth_axis_rx_core;

  logic clk = 1'b0;
  logic reset;
  logic busy, err;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  eth_axis_rx_core_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1)) s_if ();
  eth_axis_rx_core_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1)) m_if ();
  eth_hdr_if h_if ();

  eth_axis_rx_core dut (
    .clk                            (clk),
    .reset                          (reset),
    .s_axis                         (s_if),
    .m_eth_hdr                      (h_if),
    .m_eth_payload_axis             (m_if),
    .busy                           (busy),
    .error_header_early_termination (err)
  );

  // Monitor: records completed output handshakes, sampled mid-cycle.
  logic [9:0]   pay_q[$];   // {tuser, tlast, tdata}
  logic [111:0] hdr_q[$];   // {dest, src, type}
  int pay_vld_cyc = 0, hdr_vld_cyc = 0, err_cyc = 0;

  always @(negedge clk) begin
    if (m_if.tvalid && m_if.tready) pay_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
    if (h_if.valid && h_if.ready) hdr_q.push_back({h_if.dest_mac, h_if.src_mac, h_if.eth_type});
    if (m_if.tvalid) pay_vld_cyc++;
    if (h_if.valid)  hdr_vld_cyc++;
    if (err)         err_cyc++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int waited = 0;
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tuser  = user;
    s_if.tkeep  = 1'b1;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      waited++;
      if (waited > 300) begin
        check_eq("send_timeout", waited, 0);
        break;
      end
    end
    step();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] base);
    for (int i = 0; i < 14; i++) send_byte(base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic exp_hdr(input int idx, input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    if (idx < hdr_q.size()) begin
      check_eq("hdr_dest", hdr_q[idx][111:64], d);
      check_eq("hdr_src",  hdr_q[idx][63:16],  s);
      check_eq("hdr_type", hdr_q[idx][15:0],   t);
    end else check_eq("hdr_missing", hdr_q.size(), idx + 1);
  endtask

  task automatic exp_pay(input int idx, input logic [7:0] d, input logic last, input logic user);
    if (idx < pay_q.size()) check_eq($sformatf("pay[%0d]", idx), pay_q[idx], {user, last, d});
    else check_eq("pay_missing", pay_q.size(), idx + 1);
  endtask

  int  pb, hb, hv0, pv0, e0;
  bit  tx_done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t limit=1ms", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0; s_if.tkeep = 1'b1;
    m_if.tready = 1'b1;
    h_if.ready  = 1'b1;

    // ---- reset state
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_s_tready", s_if.tready, 0);
    check_eq("rst_hdr_vld",  h_if.valid, 0);
    check_eq("rst_pay_vld",  m_if.tvalid, 0);
    check_eq("rst_busy",     busy, 0);
    check_eq("rst_err",      err, 0);
    check_eq("rst_dest",     h_if.dest_mac, 0);
    check_eq("rst_tdata",    m_if.tdata, 0);
    check_eq("rst_tlast",    m_if.tlast, 0);
    check_eq("rst_tkeep",    m_if.tkeep, 1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check_eq("post_rst_tready", s_if.tready, 1);
    step();

    // ---- normal frame, sinks always ready
    pb = pay_q.size(); hb = hdr_q.size(); hv0 = hdr_vld_cyc;
    send_byte(8'h00, 1'b0, 1'b0);
    check_eq("busy_rise", busy, 1);
    for (int i = 1; i < 14; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b1, 1'b0);
    check_eq("busy_fall", busy, 0);
    repeat (4) step();
    exp_hdr(hb, 48'h000102030405, 48'h060708090A0B, 16'h0C0D);
    check_eq("n1_hdr_cnt", hdr_q.size() - hb, 1);
    check_eq("n1_hdr_vld_cycles", hdr_vld_cyc - hv0, 1);
    check_eq("n1_pay_cnt", pay_q.size() - pb, 3);
    exp_pay(pb + 0, 8'hAA, 1'b0, 1'b0);
    exp_pay(pb + 1, 8'hBB, 1'b0, 1'b0);
    exp_pay(pb + 2, 8'hCC, 1'b1, 1'b0);

    // ---- early termination inside the header, then a good frame
    hv0 = hdr_vld_cyc; pv0 = pay_vld_cyc; e0 = err_cyc; hb = hdr_q.size(); pb = pay_q.size();
    for (int i = 0; i < 10; i++) send_byte(8'(i), i == 9, 1'b0);
    repeat (3) step();
    check_eq("et_err_cycles", err_cyc - e0, 1);
    check_eq("et_hdr_vld",    hdr_vld_cyc - hv0, 0);
    check_eq("et_pay_vld",    pay_vld_cyc - pv0, 0);
    check_eq("et_busy",       busy, 0);
    send_hdr(8'h20);
    send_byte(8'h55, 1'b1, 1'b0);
    repeat (4) step();
    exp_hdr(hb, 48'h202122232425, 48'h262728292A2B, 16'h2C2D);
    exp_pay(pb, 8'h55, 1'b1, 1'b0);
    check_eq("et_pay_cnt", pay_q.size() - pb, 1);

    // ---- header backpressure with a second frame queued
    hb = hdr_q.size(); pb = pay_q.size();
    h_if.ready = 1'b0;
    send_hdr(8'h30);
    send_byte(8'h71, 1'b0, 1'b0);
    send_byte(8'h72, 1'b1, 1'b0);
    fork
      begin
        send_hdr(8'h40);
        send_byte(8'h81, 1'b1, 1'b0);
      end
      begin
        @(negedge clk);
        check_eq("hbp_tready_blocked", s_if.tready, 0);
        repeat (20) step();
        @(negedge clk);
        check_eq("hbp_hold_vld",  h_if.valid, 1);
        check_eq("hbp_hold_dest", h_if.dest_mac, 48'h303132333435);
        check_eq("hbp_hold_type", h_if.eth_type, 16'h3C3D);
        check_eq("hbp_tready_still0", s_if.tready, 0);
        step();
        h_if.ready = 1'b1;
      end
    join
    repeat (4) step();
    check_eq("hbp_hdr_cnt", hdr_q.size() - hb, 2);
    exp_hdr(hb,     48'h303132333435, 48'h363738393A3B, 16'h3C3D);
    exp_hdr(hb + 1, 48'h404142434445, 48'h464748494A4B, 16'h4C4D);
    exp_pay(pb + 0, 8'h71, 1'b0, 1'b0);
    exp_pay(pb + 1, 8'h72, 1'b1, 1'b0);
    exp_pay(pb + 2, 8'h81, 1'b1, 1'b0);

    // ---- payload backpressure: 64-byte payload, tready toggling
    hb = hdr_q.size(); pb = pay_q.size();
    tx_done = 1'b0;
    fork
      begin
        send_hdr(8'h50);
        for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63, 1'b0);
        tx_done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !tx_done; c++) begin
          step();
          m_if.tready = ~m_if.tready;
        end
      end
    join
    m_if.tready = 1'b1;
    repeat (5) step();
    check_eq("pbp_pay_cnt", pay_q.size() - pb, 64);
    for (int i = 0; i < 64; i++) exp_pay(pb + i, 8'(i), i == 63, 1'b0);
    exp_hdr(hb, 48'h505152535455, 48'h565758595A5B, 16'h5C5D);

    // ---- tuser passthrough on the last beat only
    pb = pay_q.size();
    send_hdr(8'h60);
    send_byte(8'h91, 1'b0, 1'b0);
    send_byte(8'h92, 1'b0, 1'b0);
    send_byte(8'h93, 1'b1, 1'b1);
    repeat (4) step();
    exp_pay(pb + 0, 8'h91, 1'b0, 1'b0);
    exp_pay(pb + 1, 8'h92, 1'b0, 1'b0);
    exp_pay(pb + 2, 8'h93, 1'b1, 1'b1);

    // ---- reset in the middle of the payload, header left pending
    h_if.ready = 1'b0;
    send_hdr(8'h70);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
    reset = 1'b0;
    step();
    @(negedge clk);
    check_eq("mr_hdr_vld", h_if.valid, 0);
    check_eq("mr_pay_vld", m_if.tvalid, 0);
    check_eq("mr_busy",    busy, 0);
    check_eq("mr_tready",  s_if.tready, 0);
    step();
    hb = hdr_q.size(); pb = pay_q.size();
    h_if.ready = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    send_hdr(8'hE0);
    send_byte(8'hF1, 1'b1, 1'b0);
    repeat (4) step();
    check_eq("mr_hdr_cnt", hdr_q.size() - hb, 1);
    exp_hdr(hb, 48'hE0E1E2E3E4E5, 48'hE6E7E8E9EAEB, 16'hECED);
    check_eq("mr_pay_cnt", pay_q.size() - pb, 1);
    exp_pay(pb, 8'hF1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_axis_rx_core.md
Name: eth_axis_rx_core

Overview:
- Receive-side Ethernet frame parser.
- Sits between the MAC/MII AXI-Stream byte stream and the upper protocol layers.
- Strips the 14-byte Ethernet header (destination MAC, source MAC, EtherType) into a separate valid/ready header channel.
- Forwards the remaining bytes as an AXI-Stream payload, with tlast/tuser carried through.

Parameters:
- DATA_WIDTH, 8, stream data width in bits. Only 8 is supported; any other value is an elaboration error.
- KEEP_ENABLE, (DATA_WIDTH>8), enables the tkeep path. When 0, m_eth_payload_axis_tkeep is driven all-ones.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.

Ports:
- Interface (already decided): one clock; reset is synchronous and active-low.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  incoming frame bytes.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  frame error flag, meaningful on the tlast beat.
- m_eth_hdr_valid  out  1  header valid.
- m_eth_hdr_ready  in  1  header accepted.
- m_eth_dest_mac  out  48  destination MAC; byte 0 of the frame lands in bits [47:40].
- m_eth_src_mac  out  48  source MAC; byte 6 lands in bits [47:40].
- m_eth_type  out  16  EtherType; byte 12 lands in bits [15:8].
- m_eth_payload_axis_tdata  out  DATA_WIDTH  payload byte.
- m_eth_payload_axis_tkeep  out  KEEP_WIDTH  payload keep.
- m_eth_payload_axis_tvalid  out  1  payload valid.
- m_eth_payload_axis_tready  in  1  payload ready.
- m_eth_payload_axis_tlast  out  1  payload last.
- m_eth_payload_axis_tuser  out  1  payload error, copied from s_axis_tuser.
- busy  out  1  a frame is in progress.
- error_header_early_termination  out  1  one-cycle error pulse.

Behaviour:
- Reset (reset=0 at a clock edge):
  - Byte pointer cleared; state goes to IDLE.
  - m_eth_hdr_valid=0, m_eth_payload_axis_tvalid=0, busy=0, error pulse=0, s_axis_tready=0.
  - Header fields and payload tdata/tlast/tuser are cleared to 0.
  - s_axis_tready rises on the first cycle after reset deasserts.
  - Reset asserted mid-frame aborts the frame; no header and no further payload are emitted for it.
- A byte is transferred when tvalid & tready are both 1. Outputs hold stable while valid=1 and ready=0.
- States:
  - IDLE: waiting for a frame.
  - HEADER: a 4-bit pointer counts 0..13.
  - PAYLOAD: forwarding bytes.
  - DROP: discarding until tlast.
- IDLE/HEADER:
  - s_axis_tready = !m_eth_hdr_valid. A new header cannot start while the previous header is still unaccepted.
  - Each accepted byte is shifted into the header field selected by the pointer.
- Accepting byte 13 (the 14th byte) with tlast=0:
  - m_eth_hdr_valid=1 on the next cycle.
  - Go to PAYLOAD.
- m_eth_hdr_valid is cleared the cycle after m_eth_hdr_ready=1 is sampled while valid.
- tlast on any header byte 0..13:
  - error_header_early_termination=1 for exactly one cycle.
  - No header is emitted and no payload is emitted; return to IDLE.
  - A frame therefore needs at least one payload byte.
- PAYLOAD:
  - Each input byte appears on the payload output one cycle later, through a 2-entry skid buffer (output register plus temp register).
  - s_axis_tready = !(temp register full). This gives full throughput of one byte per cycle while the sink is ready, and no data loss on stalls.
  - tlast/tuser/tkeep are carried with their byte.
  - Accepting the tlast byte returns the state to IDLE.
- DROP state is not entered under normal operation (reserved). Implementations merge it into the early-termination path.
- busy:
  - Rises on the cycle after the first header byte is accepted.
  - Falls on the cycle after the input tlast byte is accepted, or after early termination.
- Back-to-back frames: the next frame's first header byte is accepted on the cycle after the previous tlast, provided the header channel is free.

Test Plan:
- Normal frame, sinks always ready: input bytes 00..0D then payload AA BB CC with tlast on CC. Required response:
  - dest_mac=0x000102030405, src_mac=0x060708090A0B, eth_type=0x0C0D.
  - m_eth_hdr_valid high for 1 cycle.
  - Payload AA,BB,CC, with tlast only on CC and tuser=0.
  - busy falls after CC.
- Early termination: 10-byte frame with tlast on byte 9 -> error_header_early_termination=1 for one cycle; m_eth_hdr_valid and payload tvalid stay 0; a following good frame parses correctly.
- Header backpressure: m_eth_hdr_ready=0 for 20 cycles, with a second frame queued behind the first -> s_axis_tready=0 when the second frame's header starts; the first header is held stable; the second parses correctly after ready.
- Payload backpressure: toggle m_eth_payload_axis_tready 1/0 over a 64-byte payload (bytes 0..63) -> all 64 bytes emitted in order; no duplicates or losses; tlast on byte 63.
- Error passthrough: s_axis_tuser=1 on the last payload byte -> m_eth_payload_axis_tuser=1 on that same output beat only.
- Reset mid-payload: assert reset after 5 payload bytes -> next cycle all valids=0 and busy=0; a subsequent clean frame parses correctly.
